// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32 opcode constants, instruction format enum and classifier shared by decoder and encoder.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LOADFP = 7'b0000111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  function automatic fmt_e classify(input logic [6:0] op);
    return op == OP_R   ? FMT_R :
           op == OP_S   ? FMT_S :
           op == OP_B   ? FMT_B :
           op == OP_LUI ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_I;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packing and immediate range check for one instruction.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  func3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  fmt_e fmt;
  logic signed [31:0] simm;
  always_comb begin
    fmt  = classify(opcode);
    simm = imm;
    unique case (fmt)
      FMT_R:   instr = {func7, rs2, rs1, func3, rd, opcode};
      FMT_S:   instr = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:   instr = {imm[31:12], rd, opcode};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = {imm[11:0], rs1, func3, rd, opcode};
    endcase
    unique case (fmt)
      FMT_R:   err = 1'b0;
      FMT_B:   err = imm[0] || simm < -32'sd4096 || simm > 32'sd4094;
      FMT_U:   err = imm[11:0] != 12'd0;
      FMT_J:   err = imm[0] || simm < -32'sd1048576 || simm > 32'sd1048574;
      default: err = simm < -32'sd2048 || simm > 32'sd2047;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: ready/valid wrapper around instr_pack with a 1-deep output register,
// byte-address counter and saturating error counter.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        func3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count,
  input  logic              clear
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  logic [31:0]       instr;
  logic              err;
  logic              accept;
  logic [ADDR_W-1:0] next_addr;
  instr_pack u_pack (
    .opcode(opcode),
    .rd(rd),
    .func3(func3),
    .rs1(rs1),
    .rs2(rs2),
    .func7(func7),
    .imm(imm),
    .instr(instr),
    .err(err)
  );
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE;
      out_err   <= 1'b0;
      err_count <= '0;
      next_addr <= BASE;
    end else if (clear) begin
      out_valid <= 1'b0;
      err_count <= '0;
      next_addr <= BASE;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= instr;
      out_addr  <= next_addr;
      out_err   <= err;
      next_addr <= next_addr + ADDR_W'(4);
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random stimulus checked against an arithmetic reference model.
module tb_instr_encoder;
  logic        clk = 0, rst = 0, in_valid = 0, out_ready = 1, clear = 0;
  logic [6:0]  opcode = 0, func7 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0]  func3 = 0;
  logic [31:0] imm = 0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;
  int checks = 0, failures = 0;
  logic        m_valid = 0, m_err = 0;
  logic [31:0] m_instr = 0;
  logic [9:0]  m_addr = 0, m_next = 0;
  int          m_cnt = 0;
  logic [6:0]  ops [10] = '{7'h33, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h13, 7'h03, 7'h07, 7'h73, 7'h67};

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_instr();
    logic [31:0] base = {20'd0, 5'd0, opcode} | (32'(rd) << 7) | (32'(func3) << 12) | (32'(rs1) << 15);
    case (opcode)
      7'h33: return base | (32'(rs2) << 20) | (32'(func7) << 25);
      7'h23: return (base & ~(32'h1F << 7)) | ((imm & 32'h1F) << 7) | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      7'h63: return (base & ~(32'h1F << 7)) | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8)
                    | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
      7'h37: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(opcode);
      7'h6F: return (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 20) & 1) << 31) | (32'(rd) << 7) | 32'(opcode);
      default: return base | ((imm & 32'hFFF) << 20);
    endcase
  endfunction

  function automatic logic ref_err();
    int v = $signed(imm);
    case (opcode)
      7'h33: return 0;
      7'h63: return (v % 2 != 0) || v < -4096 || v > 4094;
      7'h6F: return (v % 2 != 0) || v < -1048576 || v > 1048574;
      7'h37: return (imm % 4096) != 0;
      default: return v < -2048 || v > 2047;
    endcase
  endfunction

  // One clock: check in_ready, advance the model, then compare all outputs just after the edge.
  task automatic step(input string tag);
    bit acc;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!clear && (!m_valid || out_ready)));
    acc = in_valid && !clear && (!m_valid || out_ready);
    @(posedge clk);
    if (clear) begin
      m_valid = 0; m_next = 0; m_cnt = 0;
    end else if (acc) begin
      m_valid = 1; m_instr = ref_instr(); m_err = ref_err(); m_addr = m_next; m_next = m_next + 10'd4;
      if (m_err && m_cnt < 255) m_cnt++;
    end else if (out_ready) m_valid = 0;
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".out_instr"}, out_instr, m_instr);
      chk({tag, ".out_addr"}, 32'(out_addr), 32'(m_addr));
      chk({tag, ".out_err"}, 32'(out_err), 32'(m_err));
    end
  endtask

  task automatic set(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = d; func3 = f3; rs1 = s1; rs2 = s2; func7 = f7; imm = im; in_valid = 1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_err = 0; m_addr = 0; m_next = 0; m_cnt = 0;
  endtask

  initial begin
    rst = 1;
    #12;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_instr", out_instr, 0);
    chk("rst.out_addr", 32'(out_addr), 0);
    chk("rst.err_count", 32'(err_count), 0);
    @(negedge clk); rst = 0;
    set(7'h13, 1, 0, 2, 9, 7'h55, 32'hFFFFFFFF);
    step("addi");
    chk("addi.const", out_instr, 32'hFFF10093);
    chk("addi.addr", 32'(out_addr), 0);
    chk("addi.err", 32'(out_err), 0);
    in_valid = 0; clear = 1; step("clr0"); clear = 0;
    set(7'h33, 3, 0, 1, 2, 0, 32'h12345678);
    step("add");
    chk("add.const", out_instr, 32'h002081B3);
    chk("add.addr", 32'(out_addr), 0);
    set(7'h63, 0, 0, 1, 2, 0, 8);
    step("beq");
    chk("beq.const", out_instr, 32'h00208463);
    chk("beq.addr", 32'(out_addr), 4);
    set(7'h6F, 1, 0, 0, 0, 0, 2048);
    step("jal");
    chk("jal.const", out_instr, 32'h001000EF);
    set(7'h6F, 1, 0, 0, 0, 0, 3);
    step("jal_odd");
    chk("jal_odd.err", 32'(out_err), 1);
    chk("jal_odd.cnt", 32'(err_count), 1);
    in_valid = 0; clear = 1; step("clr1"); clear = 0;
    set(7'h13, 1, 0, 2, 0, 0, 4096);
    for (int i = 0; i < 300; i++) step("addi4096");
    chk("sat.cnt", 32'(err_count), 255);
    chk("sat.imm", {20'd0, out_instr[31:20]}, 0);
    chk("sat.err", 32'(out_err), 1);
    // Backpressure: word held three cycles while a new word waits at the input.
    set(7'h23, 0, 2, 4, 5, 0, 32'hFFFFF800);
    out_ready = 0;
    step("bp_load");
    set(7'h37, 7, 0, 0, 0, 0, 32'hABCDE000);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      chk("bp.in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    step("bp_rel");
    in_valid = 0;
    step("bp_drain");
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 10);
      set(k == 10 ? 7'($urandom) : ops[k], 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom),
          $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 49) == 0;
      step("rand");
    end
    clear = 0; out_ready = 1;
    set(7'h13, 1, 0, 2, 0, 0, 5000);
    step("pre_rst");
    @(negedge clk); rst = 1; #1;
    chk("async.out_valid", 32'(out_valid), 0);
    chk("async.out_addr", 32'(out_addr), 0);
    chk("async.out_instr", out_instr, 0);
    chk("async.err_count", 32'(err_count), 0);
    model_reset();
    @(negedge clk); rst = 0;
    set(7'h33, 3, 0, 1, 2, 0, 0);
    step("post_rst");
    chk("post_rst.addr", 32'(out_addr), 0);
    set(7'h13, 1, 0, 2, 0, 0, 9999);
    step("pre_clr");
    clear = 1;
    step("clr_drop");
    chk("clr.cnt", 32'(err_count), 0);
    chk("clr.valid", 32'(out_valid), 0);
    clear = 0;
    set(7'h33, 3, 0, 1, 2, 0, 0);
    step("post_clr");
    chk("post_clr.addr", 32'(out_addr), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the output byte-address counter.
REQ-002 SHALL have parameter BASE_ADDR, default 0: address of the first emitted word (word-aligned).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-004 SHALL have the following ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous active-high reset.
- in_valid  in  1: field set valid.
- in_ready  out  1: field set accepted when in_valid&&in_ready.
- opcode  in  7: instruction opcode.
- rd  in  5: destination register.
- func3  in  3: funct3.
- rs1  in  5: source register 1.
- rs2  in  5: source register 2.
- func7  in  7: funct7.
- imm  in  32: signed immediate (byte offset for B/J, full value for U).
- out_valid  out  1: encoded word valid.
- out_ready  in  1: consumer accepts when out_valid&&out_ready.
- out_instr  out  32: encoded instruction.
- out_addr  out  ADDR_W: byte address of out_instr.
- out_err  out  1: immediate not representable for out_instr.
- err_count  out  8: saturating count of accepted erroneous words.
- clear  in  1: synchronous restart of address and error count.

Function
REQ-005 SHALL classify opcode: 0110011=R; 0100011=S; 1100011=B; 0110111=U; 1101111=J; 0010011, 0000011, 0000111, 1110011, 1100111 and all others=I.
REQ-006 SHALL encode R as {func7,rs2,rs1,func3,rd,opcode}.
REQ-007 SHALL encode I as {imm[11:0],rs1,func3,rd,opcode}.
REQ-008 SHALL encode S as {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}.
REQ-009 SHALL encode B as {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}.
REQ-010 SHALL encode U as {imm[31:12],rd,opcode}.
REQ-011 SHALL encode J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-012 SHALL ignore, and not place in out_instr, any field the selected format does not use.
REQ-013 SHALL flag out_err when the immediate is not representable:
- I/S: imm outside [-2048,2047].
- B: imm outside [-4096,4094] or imm[0]=1.
- J: imm outside [-1048576,1048574] or imm[0]=1.
- U: imm[11:0]!=0.
- R: never.
REQ-014 SHALL still emit the truncated encoding when out_err=1.
REQ-015 SHALL register the output with latency 1: a word accepted at edge N is valid on out_* after edge N.
REQ-016 SHALL drive in_ready = !out_valid || out_ready, sustaining one word per cycle under no backpressure.
REQ-017 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-018 SHALL assign out_addr = BASE_ADDR for the first accepted word, then +4 per accepted word, wrapping modulo 2^ADDR_W.
REQ-019 SHALL increment err_count on each accepted word with an error, saturating at 255.
REQ-020 SHALL, on clear, set the next address to BASE_ADDR, set err_count to 0 and out_valid to 0, and force in_ready low that cycle; clear wins over a simultaneous handshake, which is dropped.

Reset
REQ-021 SHALL, on rst asserted, immediately reset out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0 and the next-address counter to BASE_ADDR.
REQ-022 SHALL discard any in-flight word on reset mid-stream; the first post-reset accepted word SHALL receive BASE_ADDR.

Structure
REQ-023 SHALL place the opcode constants and the format enum (R/I/S/B/U/J) in shared package riscv_pkg, used by both the existing decoder and this block.
REQ-024 SHALL implement the combinational format/encode/range check as sub-module instr_pack, with the handshake and counters in instr_encoder.

Verification
REQ-025 SHALL cover ADDI: opcode=0010011, rd=1, f3=0, rs1=2, imm=-1 -> out_instr=0xFFF10093, out_err=0, out_addr=0.
REQ-026 SHALL cover back-to-back ADD then BEQ:
- ADD: opcode=0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> 0x002081B3 at addr 0.
- BEQ: opcode=1100011, rs1=1, rs2=2, imm=8 -> 0x00208463 at addr 4.
REQ-027 SHALL cover JAL: opcode=1101111, rd=1, imm=2048 -> out_instr=0x001000EF; with imm=3 -> out_err=1 and err_count incremented.
REQ-028 SHALL cover ADDI with imm=4096 -> out_err=1, out_instr imm bits=0x000; repeated 300 times -> err_count=255.
REQ-029 SHALL cover backpressure: out_ready low for 3 cycles -> in_ready=0 and out_instr/out_addr held; a word accepted after release is emitted the next cycle, none lost or duplicated.
REQ-030 SHALL cover reset and clear:
- rst asserted mid-stream -> outputs reset asynchronously, next word at addr 0.
- clear together with in_valid -> word dropped, err_count=0.
